// File: rtl/playlist_ctrl.sv
// Playlist sequencer: turns button pulses and song_done into play, song select, seek and player_reset.
// Optional build macro PLAYLIST_REPEAT_EN: loop back to song 0 and keep playing after the last song ends.
module playlist_ctrl #(
  parameter int NUM_SONGS      = 4,
  parameter int SONG_SEL_WIDTH = 2,
  parameter int CLEAR_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play_button,
  input  logic                      next_button,
  input  logic                      prev_button,
  input  logic                      ff_button,
  input  logic                      rewind_button,
  input  logic                      song_done,
  output logic                      play,
  output logic [SONG_SEL_WIDTH-1:0] song,
  output logic                      ff,
  output logic                      rewind,
  output logic                      player_reset,
  output logic                      playing
);

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    PLAYING = 2'd1,
    SWITCH  = 2'd2
  } state_t;

  localparam logic [SONG_SEL_WIDTH-1:0] LAST_SONG = SONG_SEL_WIDTH'(NUM_SONGS - 1);
  localparam logic [3:0]                CLR_LOAD  = 4'(CLEAR_CYCLES - 1);

`ifdef PLAYLIST_REPEAT_EN
  localparam logic WRAP_RESUME = 1'b1;
`else
  localparam logic WRAP_RESUME = 1'b0;
`endif

  state_t                    state, state_nxt;
  logic [SONG_SEL_WIDTH-1:0] song_nxt, song_inc, song_dec;
  logic                      resume, resume_nxt;
  logic                      enter_switch;
  logic [3:0]                clr_cnt;

  assign song_inc = (song == LAST_SONG) ? '0 : song + 1'b1;
  assign song_dec = (song == '0) ? LAST_SONG : song - 1'b1;

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt    = state;
    song_nxt     = song;
    resume_nxt   = resume;
    enter_switch = 1'b0;
    unique case (state)
      PAUSED: begin
        if (next_button) begin
          enter_switch = 1'b1;
          song_nxt     = song_inc;
          resume_nxt   = 1'b0;
        end else if (prev_button) begin
          enter_switch = 1'b1;
          song_nxt     = song_dec;
          resume_nxt   = 1'b0;
        end else if (play_button) begin
          state_nxt = PLAYING;
        end
      end
      PLAYING: begin
        if (song_done) begin
          enter_switch = 1'b1;
          // Reaching the start while rewinding restarts the same song, paused.
          if (rewind) begin
            resume_nxt = 1'b0;
          end else if (song != LAST_SONG) begin
            song_nxt   = song + 1'b1;
            resume_nxt = 1'b1;
          end else begin
            song_nxt   = '0;
            resume_nxt = WRAP_RESUME;
          end
        end else if (next_button) begin
          enter_switch = 1'b1;
          song_nxt     = song_inc;
          resume_nxt   = 1'b1;
        end else if (prev_button) begin
          enter_switch = 1'b1;
          song_nxt     = song_dec;
          resume_nxt   = 1'b1;
        end else if (play_button) begin
          state_nxt = PAUSED;
        end
      end
      SWITCH: begin
        if (clr_cnt == 4'd0) begin
          state_nxt = resume ? PLAYING : PAUSED;
        end
      end
      default: state_nxt = PAUSED;
    endcase
    if (enter_switch) begin
      state_nxt = SWITCH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= PAUSED;
      song         <= '0;
      resume       <= 1'b0;
      clr_cnt      <= 4'd0;
      play         <= 1'b0;
      playing      <= 1'b0;
      ff           <= 1'b0;
      rewind       <= 1'b0;
      player_reset <= 1'b0;
    end else begin
      state        <= state_nxt;
      song         <= song_nxt;
      resume       <= resume_nxt;
      play         <= (state_nxt == PLAYING);
      playing      <= (state_nxt == PLAYING);
      ff           <= (state_nxt == PLAYING) & ff_button & ~rewind_button;
      rewind       <= (state_nxt == PLAYING) & rewind_button & ~ff_button;
      player_reset <= (state_nxt == SWITCH);
      if (enter_switch) begin
        clr_cnt <= CLR_LOAD;
      end else if (state == SWITCH && clr_cnt != 4'd0) begin
        clr_cnt <= clr_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_playlist_ctrl.sv
// Directed bench for playlist_ctrl (default geometry: 4 songs, 2 clear cycles).
module tb_playlist_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_button, next_button, prev_button;
  logic       ff_button, rewind_button, song_done;
  logic       play, ff, rewind, player_reset, playing;
  logic [1:0] song;

  int errors = 0;
  int checks = 0;

  playlist_ctrl #(.NUM_SONGS(4), .SONG_SEL_WIDTH(2), .CLEAR_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .play_button  (play_button),
    .next_button  (next_button),
    .prev_button  (prev_button),
    .ff_button    (ff_button),
    .rewind_button(rewind_button),
    .song_done    (song_done),
    .play         (play),
    .song         (song),
    .ff           (ff),
    .rewind       (rewind),
    .player_reset (player_reset),
    .playing      (playing)
  );

  always #5 clk = ~clk;

  // Observed status packed as {play, playing, ff, rewind, player_reset, song}.
  logic [6:0] st;
  assign st = {play, playing, ff, rewind, player_reset, song};

  function automatic logic [6:0] v(input logic pl, input logic pg, input logic f,
                                   input logic r, input logic pr, input logic [1:0] s);
    return {pl, pg, f, r, pr, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear();
    step();
    step();
  endtask

  task automatic pulse(input int which);
    case (which)
      0: play_button = 1'b1;
      1: next_button = 1'b1;
      2: prev_button = 1'b1;
      default: song_done = 1'b1;
    endcase
    step();
    play_button = 1'b0;
    next_button = 1'b0;
    prev_button = 1'b0;
    song_done   = 1'b0;
  endtask

  localparam int PLAY = 0, NEXT = 1, PREV = 2, DONE = 3;

  task automatic test_reset();
    reset = 1'b0;
    {play_button, next_button, prev_button, ff_button, rewind_button, song_done} = '0;
    step();
    step();
    checks++;
    if (st !== v(0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", st, v(0,0,0,0,0,0));
    end
    reset = 1'b1;
    step();
    checks++;
    if (st !== v(0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want %b", st, v(0,0,0,0,0,0));
    end
  endtask

  task automatic test_play_pause();
    pulse(PLAY);
    checks++;
    if (st !== v(1,1,0,0,0,0)) begin
      errors++;
      $display("FAIL play_press: got %b want %b", st, v(1,1,0,0,0,0));
    end
    pulse(PLAY);
    checks++;
    if (st !== v(0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL pause_press: got %b want %b", st, v(0,0,0,0,0,0));
    end
  endtask

  task automatic test_next_switch();
    int pr_cnt;
    int play_during;
    pulse(PLAY);
    pulse(NEXT);
    checks++;
    if (st !== v(0,0,0,0,1,1)) begin
      errors++;
      $display("FAIL next_enter_switch: got %b want %b", st, v(0,0,0,0,1,1));
    end
    wait_clear();
    checks++;
    if (st !== v(1,1,0,0,0,1)) begin
      errors++;
      $display("FAIL next_resume: got %b want %b", st, v(1,1,0,0,0,1));
    end
    pulse(NEXT);
    pr_cnt      = int'(player_reset);
    play_during = int'(play);
    for (int i = 0; i < 5; i++) begin
      if (player_reset) play_during += int'(play);
      step();
      pr_cnt += int'(player_reset);
    end
    checks++;
    if (pr_cnt != 2 || play_during != 0) begin
      errors++;
      $display("FAIL clear_width: got %0d cycles (play high %0d) want 2 (0)", pr_cnt, play_during);
    end
    checks++;
    if (st !== v(1,1,0,0,0,2)) begin
      errors++;
      $display("FAIL next_song2_playing: got %b want %b", st, v(1,1,0,0,0,2));
    end
    pulse(PLAY);
    pulse(NEXT);
    checks++;
    if (st !== v(0,0,0,0,1,3)) begin
      errors++;
      $display("FAIL paused_next_switch: got %b want %b", st, v(0,0,0,0,1,3));
    end
    wait_clear();
    checks++;
    if (st !== v(0,0,0,0,0,3)) begin
      errors++;
      $display("FAIL paused_next_stays_paused: got %b want %b", st, v(0,0,0,0,0,3));
    end
  endtask

  task automatic test_wrap();
    pulse(NEXT);
    checks++;
    if (st !== v(0,0,0,0,1,0)) begin
      errors++;
      $display("FAIL next_wrap: got %b want %b", st, v(0,0,0,0,1,0));
    end
    wait_clear();
    pulse(PREV);
    checks++;
    if (st !== v(0,0,0,0,1,3)) begin
      errors++;
      $display("FAIL prev_wrap: got %b want %b", st, v(0,0,0,0,1,3));
    end
    wait_clear();
    pulse(NEXT);
    wait_clear();
    checks++;
    if (st !== v(0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL wrap_return: got %b want %b", st, v(0,0,0,0,0,0));
    end
  endtask

  task automatic test_seek();
    pulse(DONE);
    checks++;
    if (st !== v(0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL done_in_paused: got %b want %b", st, v(0,0,0,0,0,0));
    end
    pulse(PLAY);
    ff_button = 1'b1;
    step();
    checks++;
    if (st !== v(1,1,1,0,0,0)) begin
      errors++;
      $display("FAIL ff_held: got %b want %b", st, v(1,1,1,0,0,0));
    end
    rewind_button = 1'b1;
    step();
    checks++;
    if (st !== v(1,1,0,0,0,0)) begin
      errors++;
      $display("FAIL both_held: got %b want %b", st, v(1,1,0,0,0,0));
    end
    ff_button = 1'b0;
    step();
    checks++;
    if (st !== v(1,1,0,1,0,0)) begin
      errors++;
      $display("FAIL rewind_held: got %b want %b", st, v(1,1,0,1,0,0));
    end
    pulse(DONE);
    checks++;
    if (st !== v(0,0,0,0,1,0)) begin
      errors++;
      $display("FAIL rewind_done_switch: got %b want %b", st, v(0,0,0,0,1,0));
    end
    wait_clear();
    checks++;
    if (st !== v(0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL rewind_done_paused: got %b want %b", st, v(0,0,0,0,0,0));
    end
    rewind_button = 1'b0;
  endtask

  task automatic test_end_of_song();
    logic [6:0] want;
    pulse(PREV);
    wait_clear();
    pulse(PLAY);
    checks++;
    if (st !== v(1,1,0,0,0,3)) begin
      errors++;
      $display("FAIL last_song_playing: got %b want %b", st, v(1,1,0,0,0,3));
    end
    pulse(DONE);
    checks++;
    if (st !== v(0,0,0,0,1,0)) begin
      errors++;
      $display("FAIL last_done_switch: got %b want %b", st, v(0,0,0,0,1,0));
    end
    wait_clear();
`ifdef PLAYLIST_REPEAT_EN
    want = v(1,1,0,0,0,0);
`else
    want = v(0,0,0,0,0,0);
`endif
    checks++;
    if (st !== want) begin
      errors++;
      $display("FAIL last_done_end: got %b want %b", st, want);
    end
    if (play) pulse(PLAY);
  endtask

  task automatic test_priority();
    pulse(NEXT);
    wait_clear();
    pulse(PLAY);
    song_done   = 1'b1;
    next_button = 1'b1;
    play_button = 1'b1;
    step();
    {song_done, next_button, play_button} = '0;
    checks++;
    if (st !== v(0,0,0,0,1,2)) begin
      errors++;
      $display("FAIL priority_single_advance: got %b want %b", st, v(0,0,0,0,1,2));
    end
    wait_clear();
    checks++;
    if (st !== v(1,1,0,0,0,2)) begin
      errors++;
      $display("FAIL priority_resume: got %b want %b", st, v(1,1,0,0,0,2));
    end
    pulse(NEXT);
    checks++;
    if (st !== v(0,0,0,0,1,3)) begin
      errors++;
      $display("FAIL pre_abort_switch: got %b want %b", st, v(0,0,0,0,1,3));
    end
    reset = 1'b0;
    #1;
    checks++;
    if (st !== v(0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL reset_aborts_switch: got %b want %b", st, v(0,0,0,0,0,0));
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if (st !== v(0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL post_abort_idle: got %b want %b", st, v(0,0,0,0,0,0));
    end
  endtask

  initial begin
    test_reset();
    test_play_pause();
    test_next_switch();
    test_wrap();
    test_seek();
    test_end_of_song();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
